alu_issue_stage: RTL

Upstream operand-fetch/issue stage for the 8-bit combinational alu. It accepts packed instructions over a valid/ready handshake and reads two source operands from an internal register file. It drives registered alu_in1, alu_in2 and opcode to the alu, then writes alu_out and zero back into the register file and a status flag. A side load port preloads registers.

---
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-fetch/issue stage for the 8-bit combinational alu.
// Accepts {opcode, rd, rs1, rs2} over valid/ready and reads both sources from an
// internal register file. It drives registered operands and the opcode to the alu,
// then writes the alu result back into the register file.
// A side load port can preload any register in any state.
// Optional feature macro: ALU_ISSUE_BYPASS_EN. When it is defined, the stage also
// accepts in WB, and the result being written is forwarded to the new operands.
module alu_issue_stage #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int AW     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W+3*AW-1:0]   in_instr,
    input  logic                   ld_we,
    input  logic [AW-1:0]          ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
    output logic [DATA_W-1:0]      alu_in1,
    output logic [DATA_W-1:0]      alu_in2,
    output logic [OP_W-1:0]        opcode,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   zero,
    output logic                   zero_flag,
    output logic                   busy,
    output logic                   wb_valid,
    output logic [AW-1:0]          wb_addr,
    output logic [DATA_W-1:0]      wb_data
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [NREG];
    logic [AW-1:0]     rd_q;

    logic [OP_W-1:0]   instr_op;
    logic [AW-1:0]     instr_rd;
    logic [AW-1:0]     instr_rs1;
    logic [AW-1:0]     instr_rs2;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              accept;

    assign {instr_op, instr_rd, instr_rs1, instr_rs2} = in_instr;

`ifdef ALU_ISSUE_BYPASS_EN
    assign in_ready = (state == IDLE) || (state == WB);

    // Source select: the rf still holds the old rd value during WB, so take alu_out instead
    always_comb begin
        src1 = rf[instr_rs1];
        src2 = rf[instr_rs2];
        if (state == WB) begin
            if (instr_rs1 == rd_q) begin
                src1 = alu_out;
            end
            if (instr_rs2 == rd_q) begin
                src2 = alu_out;
            end
        end
    end
`else
    assign in_ready = (state == IDLE);
    assign src1     = rf[instr_rs1];
    assign src2     = rf[instr_rs2];
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // Register file: load port and writeback; the writeback is assigned last so it wins a same-address clash
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_we) begin
                rf[ld_addr] <= ld_data;
            end
            if (state == WB) begin
                rf[rd_q] <= alu_out;
            end
        end
    end

    // Issue FSM with registered alu operands and writeback status
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_q      <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            opcode    <= '0;
            zero_flag <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                WB: begin
                    wb_valid  <= 1'b1;
                    wb_addr   <= rd_q;
                    wb_data   <= alu_out;
                    zero_flag <= zero;
                    state     <= accept ? EXEC : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (accept) begin
                rd_q    <= instr_rd;
                alu_in1 <= src1;
                alu_in2 <= src2;
                opcode  <= instr_op;
            end
        end
    end

endmodule
